// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM, with a
// built-in sequencer that fills every RAM word with a pattern while both masters stall.
module onchip_mem_arbiter #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,

    input  logic                clear_start,
    input  logic [DATA_W-1:0]   clear_pattern,
    output logic                clear_busy,
    output logic                clear_done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {StArb, StClear} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;  // index of the most recently granted master
    logic              rd_pending_q, rd_pending_d;
    logic              rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clear_done_q, clear_done_d;

    logic req0, req1, arb_active, grant0, grant1;

    // Grants are suppressed while reset is held so the RAM sees no access.
    always_comb begin
        req0       = m0_read | m0_write;
        req1       = m1_read | m1_write;
        arb_active = reset_n && (state_q == StArb);
        grant0     = arb_active && req0 && (!req1 || last_grant_q);
        grant1     = arb_active && req1 && (!req0 || !last_grant_q);
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        rd_pending_d   = 1'b0;
        rd_owner_d     = rd_owner_q;
        clr_cnt_d      = clr_cnt_q;
        clear_done_d   = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;

        unique case (state_q)
            StArb: begin
                if (grant0) begin
                    mem_chipselect = 1'b1;
                    mem_write      = m0_write;
                    mem_address    = m0_address;
                    mem_byteenable = m0_byteenable;
                    mem_writedata  = m0_writedata;
                    last_grant_d   = 1'b0;
                    rd_pending_d   = !m0_write;
                    rd_owner_d     = 1'b0;
                end else if (grant1) begin
                    mem_chipselect = 1'b1;
                    mem_write      = m1_write;
                    mem_address    = m1_address;
                    mem_byteenable = m1_byteenable;
                    mem_writedata  = m1_writedata;
                    last_grant_d   = 1'b1;
                    rd_pending_d   = !m1_write;
                    rd_owner_d     = 1'b1;
                end
                if (clear_start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = clr_cnt_q;
                mem_byteenable = '1;
                mem_writedata  = clear_pattern;
                if (clr_cnt_q == LastAddr) begin
                    state_d      = StArb;
                    clr_cnt_d    = '0;
                    clear_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StArb;
            last_grant_q <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            clr_cnt_q    <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            clr_cnt_q    <= clr_cnt_d;
            clear_done_q <= clear_done_d;
        end
    end

    always_comb begin
        m0_waitrequest   = req0 && !grant0;
        m1_waitrequest   = req1 && !grant1;
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_readdatavalid = rd_pending_q && !rd_owner_q;
        m1_readdatavalid = rd_pending_q && rd_owner_q;
        clear_busy       = (state_q == StClear);
        clear_done       = clear_done_q;
        mem_clken        = 1'b1;
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM model, cycle-level reference model with a per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
module tb_onchip_mem_arbiter;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
    logic [3:0]        m0_byteenable = '0, m1_byteenable = '0;
    logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0]       m0_writedata = '0, m1_writedata = '0;
    logic              m0_waitrequest, m1_waitrequest;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata, mem_readdata;
    logic              clear_start = 1'b0;
    logic [31:0]       clear_pattern = '0;
    logic              clear_busy, clear_done;

    int checks = 0;
    int errors = 0;

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .clear_start(clear_start), .clear_pattern(clear_pattern),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    // RAM: registered address, unregistered output.
    logic [31:0]       ram [DEPTH];
    logic [ADDR_W-1:0] ram_addr_q = '0;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    // Reference model state
    logic [31:0] shadow [DEPTH];
    bit          md_clearing = 1'b0;
    int          md_cnt = 0;
    int          md_last = 1;
    bit          md_done = 1'b0;
    bit          md_pv = 1'b0;
    int          md_po = 0;
    logic [31:0] md_pd = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : compare
        int          g;
        logic        r0, r1, gw;
        logic [10:0] ga;
        logic [3:0]  gbe;
        logic [31:0] gd;
        forever begin
            @(negedge clk);
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            g  = -1;
            if (!reset_n) begin
                if (!r0) chk("rst_wait0", 32'(m0_waitrequest), 0);
                if (!r1) chk("rst_wait1", 32'(m1_waitrequest), 0);
                chk("rst_busy", 32'(clear_busy), 0);
                chk("rst_done", 32'(clear_done), 0);
                chk("rst_rdv0", 32'(m0_readdatavalid), 0);
                chk("rst_rdv1", 32'(m1_readdatavalid), 0);
                chk("rst_cs", 32'(mem_chipselect), 0);
                chk("rst_wr", 32'(mem_write), 0);
            end else begin
                if (!md_clearing) begin
                    if (r0 && (!r1 || md_last == 1)) g = 0;
                    else if (r1) g = 1;
                end
                chk("wait0", 32'(m0_waitrequest), 32'(r0 && g != 0));
                chk("wait1", 32'(m1_waitrequest), 32'(r1 && g != 1));
                chk("busy", 32'(clear_busy), 32'(md_clearing));
                chk("done", 32'(clear_done), 32'(md_done));
                chk("rdv0", 32'(m0_readdatavalid), 32'(md_pv && md_po == 0));
                chk("rdv1", 32'(m1_readdatavalid), 32'(md_pv && md_po == 1));
                if (md_pv) begin
                    chk("rdata0", m0_readdata, md_pd);
                    chk("rdata1", m1_readdata, md_pd);
                end
                chk("cs", 32'(mem_chipselect), 32'(md_clearing || g >= 0));
                chk("clken", 32'(mem_clken), 1);
                if (md_clearing) begin
                    chk("clr_wr", 32'(mem_write), 1);
                    chk("clr_addr", 32'(mem_address), md_cnt);
                    chk("clr_data", mem_writedata, clear_pattern);
                    chk("clr_be", 32'(mem_byteenable), 32'hF);
                end else if (g >= 0) begin
                    gw  = (g == 0) ? m0_write : m1_write;
                    ga  = (g == 0) ? m0_address : m1_address;
                    gbe = (g == 0) ? m0_byteenable : m1_byteenable;
                    gd  = (g == 0) ? m0_writedata : m1_writedata;
                    chk("mem_wr", 32'(mem_write), 32'(gw));
                    chk("mem_addr", 32'(mem_address), 32'(ga));
                    chk("mem_be", 32'(mem_byteenable), 32'(gbe));
                    if (gw) chk("mem_wdata", mem_writedata, gd);
                end else begin
                    chk("idle_wr", 32'(mem_write), 0);
                end
            end
            @(posedge clk);
            if (!reset_n) begin
                md_clearing = 1'b0; md_cnt = 0; md_last = 1; md_pv = 1'b0; md_done = 1'b0;
            end else begin
                md_done = 1'b0;
                md_pv   = 1'b0;
                if (md_clearing) begin
                    shadow[md_cnt] = clear_pattern;
                    if (md_cnt == DEPTH - 1) begin
                        md_clearing = 1'b0; md_cnt = 0; md_done = 1'b1;
                    end else begin
                        md_cnt++;
                    end
                end else begin
                    if (g >= 0) begin
                        md_last = g;
                        gw  = (g == 0) ? m0_write : m1_write;
                        ga  = (g == 0) ? m0_address : m1_address;
                        gbe = (g == 0) ? m0_byteenable : m1_byteenable;
                        gd  = (g == 0) ? m0_writedata : m1_writedata;
                        if (gw) begin
                            for (int b = 0; b < 4; b++)
                                if (gbe[b]) shadow[ga][8*b +: 8] = gd[8*b +: 8];
                        end else begin
                            md_pv = 1'b1; md_po = g; md_pd = shadow[ga];
                        end
                    end
                    if (clear_start) md_clearing = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mwrite(input int m, input logic [10:0] a, input logic [3:0] be,
                          input logic [31:0] d);
        if (m == 0) begin
            m0_write = 1'b1; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_write = 1'b1; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
        @(negedge clk);
        chk("wr_nowait", 32'((m == 0) ? m0_waitrequest : m1_waitrequest), 0);
        tick();
        m0_write = 1'b0; m1_write = 1'b0;
    endtask

    task automatic mread(input int m, input logic [10:0] a, input logic [31:0] exp,
                         input string name);
        if (m == 0) begin m0_read = 1'b1; m0_address = a; end
        else begin m1_read = 1'b1; m1_address = a; end
        @(negedge clk);
        chk({name, "_nowait"}, 32'((m == 0) ? m0_waitrequest : m1_waitrequest), 0);
        tick();
        m0_read = 1'b0; m1_read = 1'b0;
        @(negedge clk);
        chk({name, "_rdv"}, 32'((m == 0) ? m0_readdatavalid : m1_readdatavalid), 1);
        chk({name, "_other_rdv"}, 32'((m == 0) ? m1_readdatavalid : m0_readdatavalid), 0);
        chk({name, "_data"}, (m == 0) ? m0_readdata : m1_readdata, exp);
        tick();
    endtask

    task automatic rand_req(output logic rd, output logic wr, output logic [10:0] a,
                            output logic [3:0] be, output logic [31:0] d);
        int op;
        op = int'($urandom_range(0, 9));
        rd = (op >= 4 && op <= 6) || op == 9;
        wr = (op >= 7);
        a  = 11'($urandom_range(0, 15));
        be = 4'($urandom_range(1, 15));
        d  = $urandom;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  seq [4];
        int  busy_cnt, done_cnt, stall_bad;
        bit  found;
        logic acc0, acc1;

        // Contention straight out of reset: strict alternation starting with m0.
        repeat (2) tick();
        m0_read = 1'b1; m0_address = 11'd1;
        m1_read = 1'b1; m1_address = 11'd2;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seq[k] = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 9);
            if (k > 0) begin
                chk("rr_rdv0", 32'(m0_readdatavalid), 32'(k % 2 == 1));
                chk("rr_rdv1", 32'(m1_readdatavalid), 32'(k % 2 == 0));
            end
            tick();
        end
        m0_read = 1'b0; m1_read = 1'b0;
        @(negedge clk);
        chk("rr_last_rdv1", 32'(m1_readdatavalid), 1);
        tick();
        chk("rr_order0", seq[0], 0);
        chk("rr_order1", seq[1], 1);
        chk("rr_order2", seq[2], 0);
        chk("rr_order3", seq[3], 1);

        // Simple write then read-back.
        mwrite(0, 11'd5, 4'hF, 32'hDEADBEEF);
        mread(0, 11'd5, 32'hDEADBEEF, "wr_rd5");

        // Byte-lane merge.
        mwrite(1, 11'd7, 4'hF, 32'h11223344);
        mwrite(1, 11'd7, 4'b0100, 32'h00AA0000);
        mread(1, 11'd7, 32'h11AA3344, "lane7");

        // Clear sweep while m1 holds a read.
        m1_read = 1'b1; m1_address = 11'd3;
        clear_start = 1'b1; clear_pattern = 32'hA5A5A5A5;
        @(negedge clk);
        chk("clr_start_grant1", 32'(m1_waitrequest), 0);
        tick();
        clear_start = 1'b0;
        busy_cnt = 0; done_cnt = 0; stall_bad = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (clear_busy) begin
                busy_cnt++;
                if (!m1_waitrequest) stall_bad++;
            end
            if (clear_done) done_cnt++;
            tick();
        end
        m1_read = 1'b0;
        tick();
        chk("clr_busy_len", busy_cnt, 2048);
        chk("clr_m1_stalled", stall_bad, 0);
        chk("clr_done_once", done_cnt, 1);
        mread(0, 11'd0, 32'hA5A5A5A5, "clr_a0");
        mread(0, 11'd1023, 32'hA5A5A5A5, "clr_a1023");
        mread(0, 11'd2047, 32'hA5A5A5A5, "clr_a2047");

        // Clear start in the same cycle as a granted m0 read.
        mwrite(0, 11'd9, 4'hF, 32'h12345678);
        m0_read = 1'b1; m0_address = 11'd9;
        clear_start = 1'b1; clear_pattern = 32'h5A5A5A5A;
        @(negedge clk);
        chk("cs_same_grant0", 32'(m0_waitrequest), 0);
        tick();
        m0_read = 1'b0; clear_start = 1'b0;
        @(negedge clk);
        chk("cs_same_busy", 32'(clear_busy), 1);
        chk("cs_same_rdv0", 32'(m0_readdatavalid), 1);
        chk("cs_same_data", m0_readdata, 32'h12345678);
        tick();
        busy_cnt = 1;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (clear_busy) busy_cnt++;
            tick();
        end
        chk("cs_same_busy_len", busy_cnt, 2048);
        mread(0, 11'd9, 32'h5A5A5A5A, "cs_a9");
        mread(1, 11'd2047, 32'h5A5A5A5A, "cs_a2047");

        // Reset in the middle of a sweep.
        clear_start = 1'b1; clear_pattern = 32'h3C3C3C3C;
        tick();
        clear_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (clear_busy && mem_address == 11'd100) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_reached_100", 32'(found), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(clear_busy), 0);
        chk("abort_cs", 32'(mem_chipselect), 0);
        chk("abort_wr", 32'(mem_write), 0);
        chk("abort_done", 32'(clear_done), 0);
        tick();
        m0_read = 1'b1; m0_address = 11'd50;
        m1_read = 1'b1; m1_address = 11'd200;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant0", 32'(m0_waitrequest), 0);
        chk("post_rst_wait1", 32'(m1_waitrequest), 1);
        chk("post_rst_done", 32'(clear_done), 0);
        tick();
        m0_read = 1'b0;
        @(negedge clk);
        chk("post_rst_rdv0", 32'(m0_readdatavalid), 1);
        chk("post_rst_data50", m0_readdata, 32'h3C3C3C3C);
        tick();
        m1_read = 1'b0;
        @(negedge clk);
        chk("post_rst_rdv1", 32'(m1_readdatavalid), 1);
        chk("post_rst_data200", m1_readdata, 32'h5A5A5A5A);
        tick();

        // Random traffic; each master holds its request until accepted.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc0 = (m0_read | m0_write) && !m0_waitrequest;
            acc1 = (m1_read | m1_write) && !m1_waitrequest;
            tick();
            if (acc0 || !(m0_read | m0_write))
                rand_req(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
            if (acc1 || !(m1_read | m1_write))
                rand_req(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
        end
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-requester round-robin arbiter with a built-in clear sequencer, placed in front of the single-port 2048x32 on-chip RAM.
- Two Avalon-MM masters share the RAM: for example, the Nios data master and a peripheral DMA.
- On command, the clear sequencer fills every RAM word with a programmable pattern while both masters are stalled.
- The RAM has a registered address and unregistered output: readdata is valid exactly 1 cycle after the issue cycle.

Parameters:
- ADDR_W, 11, RAM word-address width.
- DEPTH, 2048, number of RAM words swept by the clear engine.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_byteenable  in  DATA_W/8  master 0 byte lanes.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  master 0 read data qualifier.
- m1_*  same 8 signals as m0_*, for master 1.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  DATA_W/8  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_readdata  in  DATA_W  from RAM.
- clear_start  in  1  single-cycle pulse that starts a clear sweep.
- clear_pattern  in  DATA_W  fill word; sampled on every clear write.
- clear_busy  out  1  high while in CLEAR.
- clear_done  out  1  1-cycle pulse after the last clear write.

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-low on reset_n.
- Register reset values:
  - state = ARB.
  - last_grant = 1, so m0 wins the first contention.
  - rd_pending = 0; rd_owner = 0.
  - clr_cnt = 0; clear_done = 0.
- Output values under reset:
  - clear_busy = 0, both readdatavalid = 0, mem_chipselect = 0, mem_write = 0.
  - waitrequest = 0 when the master is not requesting.
- Request definition: req_x = mx_read | mx_write. If read and write are both asserted, the access is a write.
- State ARB, grant is combinational in the same cycle:
  - Only one master requesting: it is granted.
  - Both requesting: grant the master that is not last_grant.
  - last_grant updates on every grant.
  - Granted master: waitrequest = 0, and its address, byteenable, write and writedata drive mem_*. mem_chipselect = 1.
  - Any requesting master that is not granted: waitrequest = 1, and it must hold its request stable.
  - No request: mem_chipselect = 0, mem_write = 0.
- Read return:
  - A granted read sets rd_pending = 1 and rd_owner = grantee at the clock edge.
  - Next cycle: mx_readdatavalid = 1 for the owner only, and both mx_readdata = mem_readdata.
  - Back-to-back reads are fully pipelined: one read per cycle; interleaving the two owners is legal.
  - Writes produce no readdatavalid.
- ARB -> CLEAR: clear_start sampled high in ARB.
  - That cycle's master grant still completes normally.
  - A read issued in that cycle returns its readdatavalid during the first CLEAR cycle.
- State CLEAR:
  - clear_busy = 1; both waitrequest = 1 whenever requesting.
  - Each cycle: mem_chipselect = 1, mem_write = 1, mem_byteenable = all ones, mem_address = clr_cnt, mem_writedata = clear_pattern.
  - clr_cnt increments by 1 per cycle.
  - clear_start is ignored while in CLEAR.
- CLEAR -> ARB: at clr_cnt == DEPTH-1, after that write.
  - clr_cnt returns to 0.
  - clear_done = 1 for the first ARB cycle.
  - Arbitration resumes in that same cycle.
  - Total sweep length: exactly DEPTH cycles.
- Reset asserted mid-operation: any sweep is aborted with no clear_done, and any pending readdatavalid is dropped.

Test Plan:
- m0 writes 0xDEADBEEF to address 5 with byteenable F, then reads address 5 -> m0_waitrequest = 0 on both cycles; m0_readdatavalid is high 1 cycle after the read issue with data 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both hold reads to addresses 1 and 2 for 4 cycles from reset -> grant order m0, m1, m0, m1; each readdatavalid arrives 1 cycle after its grant, to the correct owner.
- Byte-lane write: 0x11223344 to address 7, then byteenable 4'b0100 with data 0x00AA0000 -> readback 0x11AA3344.
- clear_start with clear_pattern 0xA5A5A5A5 while m1 holds a read -> clear_busy is high for 2048 cycles and m1 is stalled throughout; clear_done pulses once; reads of addresses 0, 1023 and 2047 return 0xA5A5A5A5.
- clear_start in the same cycle as a granted m0 read -> m0 data is returned in the first CLEAR cycle; the sweep still writes all 2048 words.
- Assert reset_n low at clr_cnt = 100 -> outputs return to reset values immediately, with no clear_done; after release, m0 arbitration works from the first cycle.
